// File: rtl/memory_stage_pkg.sv
`default_nettype none
// ============================================================================
// Module   : memory_stage_pkg
// Purpose  : Shared definitions for the MEM pipeline stage: access FSM
//            encoding, parameter defaults and MEM/WB register reset values.
// Revision : 1.0 - initial release
// ============================================================================
package memory_stage_pkg;

    typedef enum logic [0:0] {
        ST_IDLE = 1'b0,
        ST_WAIT = 1'b1
    } mem_state_t;

    localparam int C_DEF_DEPTH   = 1024;
    localparam int C_DEF_LATENCY = 1;

    localparam logic [31:0] C_WB_DATA_RST = 32'h0000_0000;
    localparam logic [4:0]  C_WB_RD_RST   = 5'd0;
    localparam logic        C_WB_WE_RST   = 1'b0;

endpackage : memory_stage_pkg
`default_nettype wire

// File: rtl/memory_stage_data_mem.sv
`default_nettype none
// ============================================================================
// Module   : memory_stage_data_mem
// Purpose  : Word-addressed data memory, synchronous write, asynchronous read.
//            Contents are not reset.
// Ports    : clk      - clock
//            we_i     - write enable (one word at the rising edge)
//            addr_i   - word index
//            wdata_i  - write data
//            rdata_o  - read data (combinational, pre-write value)
// Revision : 1.0 - initial release
// ============================================================================
module memory_stage_data_mem
    import memory_stage_pkg::*;
#(
    parameter int DEPTH = C_DEF_DEPTH,
    parameter int AW    = $clog2(DEPTH)
) (
    input  logic          clk,
    input  logic          we_i,
    input  logic [AW-1:0] addr_i,
    input  logic [31:0]   wdata_i,
    output logic [31:0]   rdata_o
);

    logic [31:0] mem_q [DEPTH];

    always_ff @(posedge clk) begin
        if (we_i) begin
            mem_q[addr_i] <= wdata_i;
        end
    end

    assign rdata_o = mem_q[addr_i];

endmodule : memory_stage_data_mem
`default_nettype wire

// File: rtl/memory_stage.sv
`default_nettype none
// ============================================================================
// Module   : memory_stage
// Purpose  : MEM stage of the five-stage RISC-V pipeline. Performs loads and
//            stores against a data memory of LATENCY cycles per access,
//            stalls upstream while an access is in flight, provides the MEM
//            bypass value and registers the MEM/WB outputs.
// Macro    : MEM_MISALIGN_EN - enables sticky misaligned-access detection;
//            misaligned stores are dropped and misaligned loads do not write
//            back. Undefined: MISALIGN is tied low.
// Ports    : clk, rst (async, active-high)
//            ALU_OUT, WD, RD, MEM_WE_ME, ME_WE, MEM_REG_ME - EX/MEM inputs
//            BP_MEM   - bypass to execute (= ALU_OUT)
//            STALL    - freeze upstream while access is incomplete
//            WB_DATA, WB_RD, WB_WE - MEM/WB registers
//            MISALIGN - sticky misaligned flag
// Revision : 1.0 - initial release
// ============================================================================
module memory_stage
    import memory_stage_pkg::*;
#(
    parameter int DEPTH   = C_DEF_DEPTH,
    parameter int LATENCY = C_DEF_LATENCY
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] ALU_OUT,
    input  logic [31:0] WD,
    input  logic [4:0]  RD,
    input  logic        MEM_WE_ME,
    input  logic        ME_WE,
    input  logic        MEM_REG_ME,
    output logic [31:0] BP_MEM,
    output logic        STALL,
    output logic [31:0] WB_DATA,
    output logic [4:0]  WB_RD,
    output logic        WB_WE,
    output logic        MISALIGN
);

    localparam int AW    = $clog2(DEPTH);
    localparam int CNT_W = (LATENCY > 1) ? $clog2(LATENCY) : 1;
    localparam logic [CNT_W-1:0] C_CNT_LAST = CNT_W'(LATENCY - 1);

    mem_state_t       state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [31:0]      wb_data_q, wb_data_d;
    logic [4:0]       wb_rd_q, wb_rd_d;
    logic             wb_we_q, wb_we_d;

    logic             w_access;
    logic             w_done;
    logic             w_mis;
    logic             w_store_we;
    logic [31:0]      w_rdata;

    // Address bits above the word index (and the byte offset when the
    // misalign check is disabled) are intentionally ignored.
    logic w_unused;
    assign w_unused = &{1'b0, ALU_OUT[31:AW+2], ALU_OUT[1:0]};

    assign w_access = MEM_WE_ME | MEM_REG_ME;

`ifdef MEM_MISALIGN_EN
    logic mis_q;
    assign w_mis = w_access & (ALU_OUT[1:0] != 2'b00);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            mis_q <= 1'b0;
        end else if (w_done && w_mis) begin
            mis_q <= 1'b1;
        end
    end
    assign MISALIGN = mis_q;
`else
    assign w_mis    = 1'b0;
    assign MISALIGN = 1'b0;
`endif

    // ------------------------------------------------------------------
    // Access FSM: IDLE takes the first access cycle, WAIT counts the rest.
    // ------------------------------------------------------------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        w_done  = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (w_access) begin
                    if (LATENCY == 1) begin
                        w_done = 1'b1;
                    end else begin
                        state_d = ST_WAIT;
                        cnt_d   = CNT_W'(1);
                    end
                end
            end
            ST_WAIT: begin
                if (!w_access) begin
                    // Defensive: upstream should never drop an access early.
                    state_d = ST_IDLE;
                    cnt_d   = '0;
                end else if (cnt_q == C_CNT_LAST) begin
                    w_done  = 1'b1;
                    state_d = ST_IDLE;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            default: begin
                state_d = ST_IDLE;
                cnt_d   = '0;
            end
        endcase
    end

    assign STALL      = w_access & ~w_done;
    assign w_store_we = MEM_WE_ME & w_done & ~w_mis;

    memory_stage_data_mem #(
        .DEPTH (DEPTH),
        .AW    (AW)
    ) u_data_mem (
        .clk     (clk),
        .we_i    (w_store_we),
        .addr_i  (ALU_OUT[AW+1:2]),
        .wdata_i (WD),
        .rdata_o (w_rdata)
    );

    // ------------------------------------------------------------------
    // MEM/WB register: bubble while stalled, otherwise capture result.
    // ------------------------------------------------------------------
    always_comb begin
        wb_data_d = wb_data_q;
        wb_rd_d   = wb_rd_q;
        wb_we_d   = 1'b0;
        if (!STALL) begin
            wb_data_d = MEM_REG_ME ? w_rdata : ALU_OUT;
            wb_rd_d   = RD;
            wb_we_d   = ME_WE & (RD != 5'd0) & ~(MEM_REG_ME & w_mis);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wb_data_q <= C_WB_DATA_RST;
            wb_rd_q   <= C_WB_RD_RST;
            wb_we_q   <= C_WB_WE_RST;
        end else begin
            wb_data_q <= wb_data_d;
            wb_rd_q   <= wb_rd_d;
            wb_we_q   <= wb_we_d;
        end
    end

    assign BP_MEM  = ALU_OUT;
    assign WB_DATA = wb_data_q;
    assign WB_RD   = wb_rd_q;
    assign WB_WE   = wb_we_q;

endmodule : memory_stage
`default_nettype wire

// File: tb/tb_memory_stage.sv
`default_nettype none
// ============================================================================
// Module   : tb_memory_stage
// Purpose  : Self-checking bench for memory_stage (LATENCY=3) with a
//            transaction-level reference model and directed vectors.
// Revision : 1.0 - initial release
// ============================================================================
module tb_memory_stage;

    localparam int DEPTH = 1024;
    localparam int LAT   = 3;

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] ALU_OUT, WD;
    logic [4:0]  RD;
    logic        MEM_WE_ME, ME_WE, MEM_REG_ME;
    logic [31:0] BP_MEM, WB_DATA;
    logic        STALL, WB_WE, MISALIGN;
    logic [4:0]  WB_RD;

    int n_checks = 0;
    int n_pass   = 0;

    memory_stage #(.DEPTH(DEPTH), .LATENCY(LAT)) dut (
        .clk        (clk),
        .rst        (rst),
        .ALU_OUT    (ALU_OUT),
        .WD         (WD),
        .RD         (RD),
        .MEM_WE_ME  (MEM_WE_ME),
        .ME_WE      (ME_WE),
        .MEM_REG_ME (MEM_REG_ME),
        .BP_MEM     (BP_MEM),
        .STALL      (STALL),
        .WB_DATA    (WB_DATA),
        .WB_RD      (WB_RD),
        .WB_WE      (WB_WE),
        .MISALIGN   (MISALIGN)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%08h, expected 0x%08h at %0t", name, act, exp, $time);
    endtask

    // ------------------------------------------------------------------
    // Reference model: each instruction occupies LAT cycles if it touches
    // memory (1 otherwise); it retires at the edge ending its last cycle.
    // ------------------------------------------------------------------
    logic [31:0] mmem [int];
    int          m_age;            // cycles already spent on current instr
    logic [31:0] m_wb_data;
    logic [4:0]  m_wb_rd;
    logic        m_wb_we;
    logic        m_known;          // WB data/rd defined by the spec
    logic        m_mis;

    function automatic logic mis_of(input logic [31:0] a, input logic acc);
`ifdef MEM_MISALIGN_EN
        return acc && (a[1:0] != 2'b00);
`else
        return 1'b0;
`endif
    endfunction

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            m_age     = 0;
            m_wb_data = 32'h0;
            m_wb_rd   = 5'd0;
            m_wb_we   = 1'b0;
            m_known   = 1'b1;
            m_mis     = 1'b0;
        end else begin
            logic acc, mis;
            int   idx;
            acc = MEM_WE_ME | MEM_REG_ME;
            mis = mis_of(ALU_OUT, acc);
            idx = int'((ALU_OUT >> 2) % DEPTH);
            if (acc && m_age < LAT - 1) begin
                m_age   = m_age + 1;
                m_wb_we = 1'b0;
            end else begin
                m_age = 0;
                if (mis) m_mis = 1'b1;
                if (MEM_REG_ME) begin
                    m_known   = mmem.exists(idx);
                    m_wb_data = m_known ? mmem[idx] : 32'h0;
                    m_wb_rd   = RD;
                    m_wb_we   = ME_WE && (RD != 0) && !mis;
                end else if (MEM_WE_ME) begin
                    m_known = 1'b0;
                    m_wb_we = ME_WE && (RD != 0);
                end else begin
                    m_known   = 1'b1;
                    m_wb_data = ALU_OUT;
                    m_wb_rd   = RD;
                    m_wb_we   = ME_WE && (RD != 0);
                end
                if (MEM_WE_ME && !mis) mmem[idx] = WD;
            end
        end
    end

    // Cycle-by-cycle compare of DUT against the model.
    always @(negedge clk) begin
        logic acc;
        acc = MEM_WE_ME | MEM_REG_ME;
        chk("stall", {31'b0, STALL}, {31'b0, acc && (m_age < LAT - 1)});
        chk("bp_mem", BP_MEM, ALU_OUT);
        chk("wb_we", {31'b0, WB_WE}, {31'b0, m_wb_we});
        chk("misalign", {31'b0, MISALIGN}, {31'b0, m_mis});
        if (m_known) begin
            chk("wb_data", WB_DATA, m_wb_data);
            chk("wb_rd", {27'b0, WB_RD}, {27'b0, m_wb_rd});
        end
    end

    task automatic idle_inputs();
        ALU_OUT = 32'h0; WD = 32'h0; RD = 5'd0;
        MEM_WE_ME = 1'b0; ME_WE = 1'b0; MEM_REG_ME = 1'b0;
    endtask

    // Drive one instruction, hold it while STALL is high, return after the
    // completion edge with inputs back at idle.
    task automatic issue(input logic [31:0] a, input logic [31:0] w, input logic [4:0] r,
                         input logic st, input logic ld, input logic we,
                         output int stalls);
        ALU_OUT = a; WD = w; RD = r; MEM_WE_ME = st; MEM_REG_ME = ld; ME_WE = we;
        stalls = 0;
        for (int k = 0; k < 10; k++) begin
            @(negedge clk);
            if (!STALL) break;
            stalls++;
            @(posedge clk); #2;
        end
        if (stalls >= 10) begin
            n_checks++;
            $display("FAIL stall_timeout: STALL still 1 after %0d cycles, expected release by %0d", stalls, LAT - 1);
        end
        @(posedge clk); #2;
        idle_inputs();
    endtask

    initial begin
        int s;
        #200000;
        $display("FAIL watchdog: simulation did not finish, %0d/%0d checks passed", n_pass, n_checks);
        $fatal(1);
    end

    initial begin
        int s;
        rst = 1'b1;
        ALU_OUT = $urandom; WD = $urandom; RD = 5'($urandom);
        MEM_WE_ME = 1'($urandom); ME_WE = 1'($urandom); MEM_REG_ME = 1'($urandom);
        repeat (2) @(posedge clk);
        #2;
        chk("rst_wb_data", WB_DATA, 32'h0);
        chk("rst_wb_rd", {27'b0, WB_RD}, 32'h0);
        chk("rst_wb_we", {31'b0, WB_WE}, 32'h0);
        chk("rst_misalign", {31'b0, MISALIGN}, 32'h0);
        idle_inputs();
        rst = 1'b0;
        #1;
        chk("rst_stall", {31'b0, STALL}, 32'h0);
        chk("rst_bp_mem", BP_MEM, 32'h0);
        @(posedge clk); #2;

        // ALU pass-through
        ALU_OUT = 32'h15; RD = 5'd5; ME_WE = 1'b1;
        #1;
        chk("pt_bp_mem", BP_MEM, 32'h15);
        chk("pt_stall", {31'b0, STALL}, 32'h0);
        @(posedge clk); #2;
        idle_inputs();
        chk("pt_wb_data", WB_DATA, 32'h15);
        chk("pt_wb_rd", {27'b0, WB_RD}, 32'd5);
        chk("pt_wb_we", {31'b0, WB_WE}, 32'd1);

        // Store then load
        issue(32'h10, 32'hDEADBEEF, 5'd0, 1'b1, 1'b0, 1'b0, s);
        chk("st_stall_cycles", s, LAT - 1);
        chk("st_wb_we", {31'b0, WB_WE}, 32'd0);
        issue(32'h10, 32'h0, 5'd7, 1'b0, 1'b1, 1'b1, s);
        chk("ld_stall_cycles", s, LAT - 1);
        chk("ld_wb_data", WB_DATA, 32'hDEADBEEF);
        chk("ld_wb_rd", {27'b0, WB_RD}, 32'd7);
        chk("ld_wb_we", {31'b0, WB_WE}, 32'd1);

        // Address wrap: byte address DEPTH*4 + 0x10 aliases word 4
        issue(32'h0000_1010, 32'h0, 5'd9, 1'b0, 1'b1, 1'b1, s);
        chk("wrap_wb_data", WB_DATA, 32'hDEADBEEF);

        // x0 suppression
        issue(32'h10, 32'h0, 5'd0, 1'b0, 1'b1, 1'b1, s);
        chk("x0_wb_we", {31'b0, WB_WE}, 32'd0);

        // Back-to-back store/load, different data
        issue(32'h24, 32'h0BAD_F00D, 5'd0, 1'b1, 1'b0, 1'b0, s);
        issue(32'h24, 32'h0, 5'd3, 1'b0, 1'b1, 1'b1, s);
        chk("b2b_wb_data", WB_DATA, 32'h0BAD_F00D);

        // Reset mid-access: pending store must be dropped
        issue(32'h20, 32'hAAAA5555, 5'd0, 1'b1, 1'b0, 1'b0, s);
        ALU_OUT = 32'h20; WD = 32'h1234; MEM_WE_ME = 1'b1;
        @(posedge clk); #2;            // now in second stall cycle
        chk("mid_stall", {31'b0, STALL}, 32'd1);
        #1 rst = 1'b1;
        #1;
        chk("mid_rst_wb_we", {31'b0, WB_WE}, 32'd0);
        @(posedge clk); #2;
        idle_inputs();
        rst = 1'b0;
        @(posedge clk); #2;
        issue(32'h20, 32'h0, 5'd4, 1'b0, 1'b1, 1'b1, s);
        chk("mid_ld_data", WB_DATA, 32'hAAAA5555);

`ifdef MEM_MISALIGN_EN
        issue(32'h20, 32'h5A5A_5A5A, 5'd0, 1'b1, 1'b0, 1'b0, s);
        chk("mis_pre", {31'b0, MISALIGN}, 32'd0);
        issue(32'h22, 32'h0000_0BAD, 5'd0, 1'b1, 1'b0, 1'b0, s);
        chk("mis_stall_cycles", s, LAT - 1);
        chk("mis_set", {31'b0, MISALIGN}, 32'd1);
        issue(32'h20, 32'h0, 5'd6, 1'b0, 1'b1, 1'b1, s);
        chk("mis_mem_kept", WB_DATA, 32'h5A5A_5A5A);
        chk("mis_sticky", {31'b0, MISALIGN}, 32'd1);
        issue(32'h21, 32'h0, 5'd6, 1'b0, 1'b1, 1'b1, s);
        chk("mis_ld_we", {31'b0, WB_WE}, 32'd0);
`endif

        repeat (2) @(posedge clk);
        #2;
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule : tb_memory_stage
`default_nettype wire

// File: doc/memory_stage.md
# memory_stage

Memory (MEM) stage of the five-stage RISC-V pipeline. It sits directly after the execute stage and consumes that stage's registered outputs: the ALU result, destination register, and the memory-write, register-write and memory-to-register controls. It also takes the store data. The stage owns the word-addressed data memory, which has a configurable access latency. It raises a stall toward the hazard unit while an access is in flight, drives the MEM bypass value back into execute, and registers the MEM/WB pipeline outputs.

## Interface
- DEPTH, 1024, data memory size in 32-bit words (power of two)
- LATENCY, 1, cycles per load/store access, minimum 1
- clk  in  1  clock; all state changes on rising edge
- rst  in  1  reset, asynchronous, active-high
- ALU_OUT  in  32  ALU result / byte address of the instruction in MEM
- WD  in  32  store data (forwarded rs2) for the instruction in MEM
- RD  in  5  destination register
- MEM_WE_ME  in  1  store instruction
- ME_WE  in  1  register write enable
- MEM_REG_ME  in  1  load instruction (write-back selects memory data)
- BP_MEM  out  32  bypass value to execute; equals ALU_OUT, combinational
- STALL  out  1  freeze IF/ID/EX and the EX/MEM register; combinational
- WB_DATA  out  32  registered write-back data
- WB_RD  out  5  registered destination register
- WB_WE  out  1  registered register-write enable
- MISALIGN  out  1  sticky misaligned-access flag (macro only, see Configuration)

## Operation
- access = MEM_WE_ME | MEM_REG_ME; word index = ALU_OUT[log2(DEPTH)+1:2]; upper address bits are ignored, so addresses wrap modulo DEPTH*4
- Non-access instruction: WB_DATA <= ALU_OUT, WB_RD <= RD, WB_WE <= ME_WE & (RD != 0); no stall
- FSM states: IDLE, WAIT
  - IDLE with access and LATENCY=1: complete in the same cycle
  - IDLE with access and LATENCY>1: go to WAIT with cnt=1
  - WAIT: cnt increments each cycle; return to IDLE on the cycle where cnt = LATENCY-1 (the completion cycle)
- STALL = access & !(completion cycle). Upstream holds all inputs stable while STALL=1.
- Completion cycle:
  - Store: mem[index] <= WD at the closing edge, written exactly once.
  - Load: WB_DATA <= mem[index] (value before any same-edge write), WB_RD <= RD, WB_WE <= ME_WE & (RD != 0).
- While STALL=1: the WB registers take a bubble (WB_WE <= 0; WB_DATA and WB_RD hold).
- Store followed by load to the same address in the next instruction returns the stored data.
- Memory contents are not reset; only registers are.

## Timing
- Reset (asynchronous): WB_DATA=0, WB_RD=0, WB_WE=0, MISALIGN=0, FSM=IDLE, cnt=0. With inputs at 0, STALL=0 and BP_MEM=0.
- Reset mid-access: the FSM is aborted and the pending store is not written.
- Non-access latency: 1 cycle from input to WB outputs.
- Access latency: LATENCY cycles. STALL is high for LATENCY-1 cycles, then the WB outputs are valid one edge after the completion cycle.
- Back-to-back accesses: IDLE is re-entered at the completion edge, and the next access starts counting the following cycle with no extra bubble.

## Configuration
- MEM_MISALIGN_EN defined:
  - a load or store with ALU_OUT[1:0] != 0 sets MISALIGN (sticky until rst)
  - the store is suppressed and the load's WB_WE is forced to 0
  - the access timing (stall cycles) is unchanged
- Not defined: the MISALIGN port is tied to 0, the low address bits are ignored, and the access proceeds normally.

## Structure
- Shared package: FSM state encoding (IDLE, WAIT); defaults for DEPTH and LATENCY; pipeline-register reset constants.
- One sub-module: data_mem (DEPTH words, synchronous write, asynchronous read).
- FSM, counter, and MEM/WB registers live in memory_stage.

## Test plan
- Reset:
  - hold rst=1 for 2 cycles with random inputs → WB_DATA=0, WB_RD=0, WB_WE=0, MISALIGN=0
  - release rst with inputs at 0 → STALL=0
- ALU pass-through:
  - ALU_OUT=0x15, RD=5, ME_WE=1 → BP_MEM=0x15 the same cycle; next edge WB_DATA=0x15, WB_RD=5, WB_WE=1
- Store then load, LATENCY=3:
  - store ALU_OUT=0x10, WD=0xDEADBEEF → STALL=1 for 2 cycles, WB_WE=0 throughout
  - load ALU_OUT=0x10, RD=7, ME_WE=1 → STALL=1 for 2 cycles; then WB_DATA=0xDEADBEEF, WB_RD=7, WB_WE=1
- x0 suppression:
  - load to RD=0 with ME_WE=1 → WB_WE=0
- Reset mid-access, LATENCY=3:
  - store 0x1234 to 0x20, assert rst during the second stall cycle, release rst
  - load 0x20 → returns the prior contents, not 0x1234
- Misalign, MEM_MISALIGN_EN defined:
  - store to 0x22 → MISALIGN=1 after the completion edge; memory at 0x20 unchanged; flag stays high on later aligned accesses
